// File: rtl/mem_write_controller.sv
// ---------------------------------------------------------------------------
// mem_write_controller
//
// Takes packed wide words from the DRAM-to-memory packer, buffers them in a
// small FIFO and writes them into one of NUM_BANKS on-chip BRAM banks at
// sequential addresses starting from a programmed base. Banks rotate on
// every transfer (ping-pong). A BRAM port arbiter grants writes per cycle.
//
// Ports:
//   clk_i           clock, all logic on rising edge
//   mem_wr_rst_n_i  asynchronous active-low reset
//   start_i         begin transfer (only honoured in IDLE)
//   base_addr_i     first BRAM address, latched on start
//   word_count_i    words in transfer, latched on start
//   data_in_i       packed word from packer
//   data_valid_i    packer write strobe, one word per high cycle
//   bram_grant_i    arbiter allows a BRAM write this cycle
//   bram_we_o       one-hot write enable of the active bank (one cycle/word)
//   bram_addr_o     write address (base + words written, wraps)
//   bram_data_o     write data
//   bank_sel_o      bank of the current/last transfer
//   busy_o          high while a transfer is running
//   done_o          one-cycle completion pulse
//   overflow_o      sticky: a word was dropped since the last start
// ---------------------------------------------------------------------------
module mem_write_controller #(
    parameter int DATA_BITWIDTH   = 163,
    parameter int ADDR_BITWIDTH   = 10,
    parameter int WCOUNT_BITWIDTH = 11,
    parameter int NUM_BANKS       = 2,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                                                 clk_i,
    input  logic                                                 mem_wr_rst_n_i,
    input  logic                                                 start_i,
    input  logic [ADDR_BITWIDTH-1:0]                             base_addr_i,
    input  logic [WCOUNT_BITWIDTH-1:0]                           word_count_i,
    input  logic [DATA_BITWIDTH-1:0]                             data_in_i,
    input  logic                                                 data_valid_i,
    input  logic                                                 bram_grant_i,
    output logic [NUM_BANKS-1:0]                                 bram_we_o,
    output logic [ADDR_BITWIDTH-1:0]                             bram_addr_o,
    output logic [DATA_BITWIDTH-1:0]                             bram_data_o,
    output logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] bank_sel_o,
    output logic                                                 busy_o,
    output logic                                                 done_o,
    output logic                                                 overflow_o
);

    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FILL_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // -----------------------------------------------------------------------
    // State and control registers
    // -----------------------------------------------------------------------
    state_t                       r_state;
    state_t                       w_next_state;
    logic                         w_start;

    logic [ADDR_BITWIDTH-1:0]     r_base;
    logic [WCOUNT_BITWIDTH-1:0]   r_count;
    logic [WCOUNT_BITWIDTH-1:0]   r_accepted;
    logic [WCOUNT_BITWIDTH-1:0]   r_written;
    logic [BANK_W-1:0]            r_bank_sel;
    logic                         r_started;   // a start has been taken since reset
    logic                         r_overflow;

    // -----------------------------------------------------------------------
    // FIFO storage
    // -----------------------------------------------------------------------
    logic [DATA_BITWIDTH-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [FILL_W-1:0]            r_fill;

    // -----------------------------------------------------------------------
    // Registered BRAM write port
    // -----------------------------------------------------------------------
    logic [NUM_BANKS-1:0]         r_bram_we;
    logic [ADDR_BITWIDTH-1:0]     r_bram_addr;
    logic [DATA_BITWIDTH-1:0]     r_bram_data;

    // -----------------------------------------------------------------------
    // Datapath decisions for this cycle
    // -----------------------------------------------------------------------
    logic                         w_run;
    logic                         w_empty;
    logic                         w_full;
    logic                         w_want_push;
    logic                         w_push;
    logic                         w_pop;
    logic                         w_drop;
    logic [DATA_BITWIDTH-1:0]     w_pop_data;
    logic [BANK_W-1:0]            w_bank_next;

    always_comb begin
        w_run       = (r_state == S_RUN);
        w_empty     = (r_fill == '0);
        w_full      = (r_fill == FILL_W'(FIFO_DEPTH));
        w_want_push = w_run && data_valid_i && (r_accepted < r_count);
        // An empty FIFO forwards an arriving word straight to the BRAM port,
        // giving single-cycle latency and one word per cycle throughput.
        w_pop       = w_run && bram_grant_i && (!w_empty || w_want_push);
        // A full FIFO can still take a word when it drains one in the same cycle.
        w_push      = w_want_push && (!w_full || w_pop);
        w_drop      = data_valid_i && !w_push;
        w_pop_data  = w_empty ? data_in_i : r_mem[r_rd_ptr];
        w_bank_next = (r_bank_sel == BANK_W'(NUM_BANKS - 1)) ? '0
                                                             : r_bank_sel + BANK_W'(1);
    end

    // -----------------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_i) begin
                    w_start      = 1'b1;
                    w_next_state = (word_count_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // r_written already counts the write being presented this cycle.
                if (r_written == r_count) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge mem_wr_rst_n_i) begin
        if (!mem_wr_rst_n_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // -----------------------------------------------------------------------
    // Transfer control: latched parameters, counters, bank, overflow
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge mem_wr_rst_n_i) begin
        if (!mem_wr_rst_n_i) begin
            r_base     <= '0;
            r_count    <= '0;
            r_accepted <= '0;
            r_written  <= '0;
            r_bank_sel <= '0;
            r_started  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_start) begin
                r_base     <= base_addr_i;
                r_count    <= word_count_i;
                r_accepted <= '0;
                r_written  <= '0;
                r_overflow <= 1'b0;
                r_started  <= 1'b1;
                // The very first transfer after reset stays on bank 0.
                if (r_started) begin
                    r_bank_sel <= w_bank_next;
                end
            end else begin
                if (w_push) begin
                    r_accepted <= r_accepted + WCOUNT_BITWIDTH'(1);
                end
                if (w_pop) begin
                    r_written <= r_written + WCOUNT_BITWIDTH'(1);
                end
            end
            // A word dropped on the start cycle still counts as an overflow.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // FIFO pointers and occupancy
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge mem_wr_rst_n_i) begin
        if (!mem_wr_rst_n_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + FILL_W'(1);
                2'b01:   r_fill <= r_fill - FILL_W'(1);
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone defines what is valid.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in_i;
        end
    end

    // -----------------------------------------------------------------------
    // BRAM write port: enable pulses once per pop, address/data hold otherwise
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge mem_wr_rst_n_i) begin
        if (!mem_wr_rst_n_i) begin
            r_bram_we   <= '0;
            r_bram_addr <= '0;
            r_bram_data <= '0;
        end else begin
            r_bram_we <= '0;
            if (w_pop) begin
                r_bram_we   <= NUM_BANKS'(1) << r_bank_sel;
                // Truncation gives the silent address wrap.
                r_bram_addr <= r_base + ADDR_BITWIDTH'(r_written);
                r_bram_data <= w_pop_data;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bram_we_o   = r_bram_we;
    assign bram_addr_o = r_bram_addr;
    assign bram_data_o = r_bram_data;
    assign bank_sel_o  = r_bank_sel;
    assign busy_o      = (r_state == S_RUN);
    assign done_o      = (r_state == S_DONE);
    assign overflow_o  = r_overflow;

endmodule
